// File: rtl/pool_pkg.sv
// Types shared by the window gather and the 2x2 max-pooling stage.
package pool_pkg;

    localparam int POOL_WIN  = 2;
    localparam int WIN_BEATS = POOL_WIN * POOL_WIN;

    typedef enum logic [1:0] {
        FILL,
        PAIR_L,
        PAIR_R,
        EMIT
    } gather_state_t;

    // Index of the element within one window: TL, TR, BL, BR.
    typedef logic [$clog2(WIN_BEATS)-1:0] beat_t;

    localparam beat_t LAST_BEAT = beat_t'(WIN_BEATS - 1);

endpackage

// File: rtl/row_line_buffer.sv
// One-row storage for the even row of a window pair.
// Single write port; two combinational reads returning the left/right
// pixels of the window whose right column is rd_addr_i.
module row_line_buffer #(
    parameter int  DATA_WIDTH = 32,
    parameter int  IMG_WIDTH  = 28,
    localparam int COL_W      = $clog2(IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [COL_W-1:0]      wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [COL_W-1:0]      rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_prev_o,
    output logic [DATA_WIDTH-1:0] rd_cur_o
);

    localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

    logic [DATA_WIDTH-1:0] mem_q [IMG_WIDTH];
    logic [COL_W-1:0]      prev_addr;

    // rd_addr_i is always an odd column when used, so prev never underflows.
    assign prev_addr = rd_addr_i - COL_ONE;

    // Capture the even row; storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_prev_o = mem_q[prev_addr];
    assign rd_cur_o  = mem_q[rd_addr_i];

endmodule

// File: rtl/pool_window_gather.sv
// Reorders a raster feature-map stream into 2x2 window order (TL, TR, BL, BR)
// for the stride-2 max-pooling stage. The even row is parked in a line
// buffer; on the odd row each column pair completes a window, which is then
// emitted over four beats while the producer is held off.
module pool_window_gather
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_error
);

    localparam int               COL_W    = $clog2(IMG_WIDTH);
    localparam int               ROW_W    = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    gather_state_t         state_q;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      win_col_q;
    logic                  win_last_q;
    beat_t                 beat_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  frame_error_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] cur_q;

    logic                  accept;
    logic                  col_end;
    logic                  at_final;
    logic                  bad_last;
    logic [COL_W-1:0]      rd_col;
    logic [DATA_WIDTH-1:0] lb_prev;
    logic [DATA_WIDTH-1:0] lb_cur;

    assign accept   = in_valid && in_ready_q;
    assign col_end  = (col_q == COL_LAST);
    assign at_final = (row_q == ROW_LAST) && col_end;
    // in_last ahead of the final position aborts the frame.
    assign bad_last = accept && in_last && !at_final;
    // During emission the counters have already moved on, so read from the
    // latched window column instead.
    assign rd_col   = (state_q == EMIT) ? win_col_q : col_q;

    row_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_WIDTH  (IMG_WIDTH)
    ) u_line_buf (
        .clk       (clk),
        .wr_en_i   (accept && (state_q == FILL)),
        .wr_addr_i (col_q),
        .wr_data_i (in_data),
        .rd_addr_i (rd_col),
        .rd_prev_o (lb_prev),
        .rd_cur_o  (lb_cur)
    );

    // Raster position of the next element; an early in_last restarts the frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (bad_last) begin
                col_d = '0;
                row_d = '0;
            end else if (col_end) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
            end else begin
                col_d = col_q + COL_ONE;
            end
        end
    end

    // Odd-row pixels of the window being assembled (data only, no reset).
    always_ff @(posedge clk) begin
        if (accept && (state_q == PAIR_L)) begin
            hold_q <= in_data;
        end
        if (accept && (state_q == PAIR_R)) begin
            cur_q <= in_data;
        end
    end

    // Gather FSM, raster counters and registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            col_q         <= '0;
            row_q         <= '0;
            win_col_q     <= '0;
            win_last_q    <= 1'b0;
            beat_q        <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            frame_error_q <= 1'b0;
            out_data_q    <= '0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            in_ready_q    <= 1'b1;
            frame_error_q <= accept && (in_last != at_final);
            case (state_q)
                FILL: begin
                    if (accept && col_end && !bad_last) begin
                        state_q <= PAIR_L;
                    end
                end
                PAIR_L: begin
                    if (accept) begin
                        state_q <= bad_last ? FILL : PAIR_R;
                    end
                end
                PAIR_R: begin
                    if (accept) begin
                        if (bad_last) begin
                            state_q <= FILL;
                        end else begin
                            state_q     <= EMIT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= lb_prev;
                            beat_q      <= '0;
                            win_col_q   <= col_q;
                            win_last_q  <= at_final;
                        end
                    end
                end
                EMIT: begin
                    in_ready_q <= 1'b0;
                    if (out_ready) begin
                        beat_q <= beat_q + beat_t'(1);
                        case (beat_q)
                            2'd0: out_data_q <= lb_cur;
                            2'd1: out_data_q <= hold_q;
                            2'd2: begin
                                out_data_q <= cur_q;
                                out_last_q <= win_last_q;
                            end
                            default: begin
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
                                in_ready_q  <= 1'b1;
                                state_q     <= (win_col_q == COL_LAST) ? FILL : PAIR_L;
                            end
                        endcase
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_pool_window_gather.sv
// Bench for pool_window_gather: a 4x4 instance for directed and random
// frames, and a 28x28 instance for random frames with input gaps.
module tb_pool_window_gather;

    typedef logic [31:0] wq_t[$];

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic [31:0] a_in_data, a_out_data;
    logic        a_in_valid, a_in_ready, a_in_last;
    logic        a_out_valid, a_out_ready, a_out_last, a_frame_error;

    logic [31:0] b_in_data, b_out_data;
    logic        b_in_valid, b_in_ready, b_in_last;
    logic        b_out_valid, b_out_ready, b_out_last, b_frame_error;

    pool_window_gather #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_last(a_in_last),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last), .frame_error(a_frame_error)
    );

    pool_window_gather #(.DATA_WIDTH(32), .IMG_WIDTH(28), .IMG_HEIGHT(28)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_last(b_in_last),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last), .frame_error(b_frame_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [31:0] got_a[$], exp_a[$], got_b[$], exp_b[$];
    bit          got_la[$], exp_la[$], got_lb[$], exp_lb[$];
    int a_rd = 0, b_rd = 0;
    int a_ferr = 0, a_lastcnt = 0, b_ferr = 0, b_lastcnt = 0;
    int a_run = 0;
    bit run_en = 1'b0;

    // Output monitor for the 4x4 instance, sampled mid-cycle.
    always @(negedge clk) begin
        #1;
        if (a_out_valid && a_out_ready) begin
            got_a.push_back(a_out_data);
            got_la.push_back(a_out_last);
            if (a_out_last) a_lastcnt++;
        end
        if (a_frame_error) a_ferr++;
        if (reset || !run_en) a_run = 0;
        else if (!a_in_ready) a_run++;
        else if (a_run != 0) begin
            chk("ready_low_run", 64'(a_run), 64'd4);
            a_run = 0;
        end
    end

    // Output monitor for the 28x28 instance.
    always @(negedge clk) begin
        #1;
        if (b_out_valid && b_out_ready) begin
            got_b.push_back(b_out_data);
            got_lb.push_back(b_out_last);
            if (b_out_last) b_lastcnt++;
        end
        if (b_frame_error) b_ferr++;
    end

    // Reference reorder: windows whose bottom-right index is below n_ok.
    function automatic wq_t window_order(input wq_t vals, input int w, input int h, input int n_ok);
        wq_t r;
        int  tl;
        for (int wr = 0; wr < h / 2; wr++) begin
            for (int wc = 0; wc < w / 2; wc++) begin
                tl = 2 * wr * w + 2 * wc;
                if (tl + w + 1 < n_ok) begin
                    r.push_back(vals[tl]);
                    r.push_back(vals[tl + 1]);
                    r.push_back(vals[tl + w]);
                    r.push_back(vals[tl + w + 1]);
                end
            end
        end
        return r;
    endfunction

    task automatic expect_a(input wq_t vals, input int n_ok);
        wq_t r;
        r = window_order(vals, 4, 4, n_ok);
        for (int i = 0; i < r.size(); i++) begin
            exp_a.push_back(r[i]);
            exp_la.push_back(n_ok == 16 && i == r.size() - 1);
        end
    endtask

    task automatic expect_b(input wq_t vals);
        wq_t r;
        r = window_order(vals, 28, 28, 784);
        for (int i = 0; i < r.size(); i++) begin
            exp_b.push_back(r[i]);
            exp_lb.push_back(i == r.size() - 1);
        end
    endtask

    task automatic compare_a(input string tag);
        chk({tag, "_count"}, 64'(got_a.size()), 64'(exp_a.size()));
        for (int i = a_rd; i < exp_a.size() && i < got_a.size(); i++) begin
            chk({tag, "_data"}, 64'(got_a[i]), 64'(exp_a[i]));
            chk({tag, "_last"}, 64'(got_la[i]), 64'(exp_la[i]));
        end
        a_rd = exp_a.size();
    endtask

    task automatic compare_b(input string tag);
        chk({tag, "_count"}, 64'(got_b.size()), 64'(exp_b.size()));
        for (int i = b_rd; i < exp_b.size() && i < got_b.size(); i++) begin
            chk({tag, "_data"}, 64'(got_b[i]), 64'(exp_b[i]));
            chk({tag, "_last"}, 64'(got_lb[i]), 64'(exp_lb[i]));
        end
        b_rd = exp_b.size();
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic a_send(input logic [31:0] d, input bit last);
        int g = 0;
        a_in_data = d; a_in_last = last; a_in_valid = 1'b1;
        while (!a_in_ready && g < 64) begin @(negedge clk); g++; end
        if (g >= 64) chk("a_in_ready_timeout", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic b_send(input logic [31:0] d, input bit last);
        int g = 0;
        b_in_data = d; b_in_last = last; b_in_valid = 1'b1;
        while (!b_in_ready && g < 64) begin @(negedge clk); g++; end
        if (g >= 64) chk("b_in_ready_timeout", 64'(b_in_ready), 64'd1);
        @(negedge clk);
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic a_frame(input wq_t vals, input int n_send, input int last_idx, input int gap_pct);
        for (int i = 0; i < n_send; i++) begin
            for (int g = 0; g < 6 && $urandom_range(99, 0) < gap_pct; g++) @(negedge clk);
            a_send(vals[i], i == last_idx);
        end
    endtask

    task automatic b_frame(input wq_t vals, input int gap_pct);
        for (int i = 0; i < vals.size(); i++) begin
            for (int g = 0; g < 6 && $urandom_range(99, 0) < gap_pct; g++) @(negedge clk);
            b_send(vals[i], i == vals.size() - 1);
        end
    endtask

    // Holds out_ready low for three cycles while element 1 is presented.
    task automatic stall_on_one();
        int g = 0;
        @(negedge clk);
        while (!(a_out_valid && a_out_data == 32'd1) && g < 200) begin @(negedge clk); g++; end
        chk("stall_target_seen", 64'(a_out_data), 64'd1);
        a_out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_data", 64'(a_out_data), 64'd1);
            chk("stall_valid", 64'(a_out_valid), 64'd1);
        end
        a_out_ready = 1'b1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wq_t f0, f1, fr;
        int  g, e0, l0;
        reset = 1'b1;
        a_in_data = '0; a_in_valid = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            f0.push_back(32'(i));
            f1.push_back(32'(100 + i));
        end

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_last", 64'(a_out_last), 64'd0);
        chk("rst_frame_error", 64'(a_frame_error), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_out_data", 64'(a_out_data), 64'd0);
        reset = 1'b0;
        #1;
        chk("in_ready_before_edge", 64'(a_in_ready), 64'd0);
        @(negedge clk);
        chk("in_ready_after_edge", 64'(a_in_ready), 64'd1);

        // Clean 4x4 frame, continuous input.
        e0 = a_ferr; l0 = a_lastcnt;
        run_en = 1'b1;
        expect_a(f0, 16);
        a_frame(f0, 16, 15, 0);
        repeat (10) @(negedge clk);
        run_en = 1'b0;
        compare_a("clean");
        chk("clean_ferr", 64'(a_ferr - e0), 64'd0);
        chk("clean_lastcnt", 64'(a_lastcnt - l0), 64'd1);

        // Downstream stall on beat 1.
        expect_a(f0, 16);
        fork
            a_frame(f0, 16, 15, 0);
            stall_on_one();
        join
        repeat (10) @(negedge clk);
        compare_a("stall");

        // Back-to-back frames.
        l0 = a_lastcnt;
        expect_a(f0, 16);
        expect_a(f1, 16);
        a_frame(f0, 16, 15, 0);
        a_frame(f1, 16, 15, 0);
        repeat (10) @(negedge clk);
        compare_a("b2b");
        chk("b2b_lastcnt", 64'(a_lastcnt - l0), 64'd2);

        // Early in_last on value 5, then a clean frame.
        e0 = a_ferr;
        expect_a(f0, 5);
        a_frame(f0, 6, 5, 0);
        repeat (6) @(negedge clk);
        chk("early_ferr", 64'(a_ferr - e0), 64'd1);
        expect_a(f0, 16);
        a_frame(f0, 16, 15, 0);
        repeat (10) @(negedge clk);
        compare_a("early");
        chk("early_ferr_total", 64'(a_ferr - e0), 64'd1);

        // Reset asserted during beat 2 of the first window.
        a_frame(f0, 6, -1, 0);
        g = 0;
        while (!(a_out_valid && a_out_data == 32'd4) && g < 20) begin @(negedge clk); g++; end
        chk("rst_beat2_seen", 64'(a_out_data), 64'd4);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
        chk("midrst_out_last", 64'(a_out_last), 64'd0);
        chk("midrst_in_ready", 64'(a_in_ready), 64'd0);
        chk("midrst_out_data", 64'(a_out_data), 64'd0);
        exp_a.push_back(32'd0); exp_la.push_back(1'b0);
        exp_a.push_back(32'd1); exp_la.push_back(1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_a(f0, 16);
        a_frame(f0, 16, 15, 0);
        repeat (10) @(negedge clk);
        compare_a("midrst");

        // Random values and ~50% input gaps on the 4x4 instance.
        l0 = a_lastcnt;
        for (int f = 0; f < 3; f++) begin
            fr.delete();
            for (int i = 0; i < 16; i++) fr.push_back($urandom);
            expect_a(fr, 16);
            a_frame(fr, 16, 15, 50);
        end
        repeat (10) @(negedge clk);
        compare_a("rand4");
        chk("rand4_lastcnt", 64'(a_lastcnt - l0), 64'd3);

        // Random 28x28 frames with gaps.
        e0 = b_ferr;
        for (int f = 0; f < 2; f++) begin
            fr.delete();
            for (int i = 0; i < 784; i++) fr.push_back($urandom);
            expect_b(fr);
            b_frame(fr, 50);
        end
        repeat (20) @(negedge clk);
        compare_b("rand28");
        chk("rand28_lastcnt", 64'(b_lastcnt), 64'd2);
        chk("rand28_ferr", 64'(b_ferr - e0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_window_gather.md
Name: pool_window_gather

Overview:
- Upstream neighbour of the 2x2/stride-2 max-pooling stage; sits between the convolution/activation output and pooling.
- Converts a raster-order feature-map stream into window order: for each 2x2 window, emits top-left, top-right, bottom-left, bottom-right, back to back.
- Buffers one even row in a line buffer and throttles the producer while each window is emitted.
- Flags the final element of a frame, and reports malformed frames.

Parameters:
- DATA_WIDTH, 32, width of one feature-map element.
- IMG_WIDTH, 28, elements per row; must be even and >= 2.
- IMG_HEIGHT, 28, rows per frame; must be even and >= 2.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_WIDTH  raster-order element.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_last  input  1  producer marks final element of frame.
- out_data  output  DATA_WIDTH  window-ordered element.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts; tie high for the pooling stage.
- out_last  output  1  asserted with 4th element of the final window.
- frame_error  output  1  one-cycle pulse on in_last/position mismatch.

Behaviour:
- Accept handshake: an input element is accepted when in_valid && in_ready.
- Output transfer: an output element moves when out_valid && out_ready.
- Reset values: out_data=0, out_valid=0, out_last=0, frame_error=0, in_ready=0 while reset is asserted, col=0, row=0, state=FILL.
- in_ready rises the first cycle after reset deasserts.
- Counters:
  - col is $clog2(IMG_WIDTH) bits and row is $clog2(IMG_HEIGHT) bits; both advance on every accepted element.
  - col wraps at IMG_WIDTH-1 and increments row.
  - row wraps at IMG_HEIGHT-1 back to 0.
- State machine:
  - FILL (even row): in_ready=1; each accepted element is written to linebuf[col]. The last column of the row moves to PAIR_L.
  - PAIR_L (odd row, even col): in_ready=1; the accepted element is held in hold_reg and the state goes to PAIR_R.
  - PAIR_R (odd row, odd col): in_ready=1; the accepted element goes to cur_reg and the state goes to EMIT with beat=0.
  - EMIT: in_ready=0; out_valid=1; beat selects out_data as 0=linebuf[col-1], 1=linebuf[col], 2=hold_reg, 3=cur_reg.
  - EMIT advances beat only when out_ready=1, and holds out_data/out_valid stable while out_ready=0.
  - After beat 3 transfers, EMIT goes to FILL if the odd row is complete, otherwise to PAIR_L.
- Latency and throughput:
  - First out_valid appears the cycle after the PAIR_R accept; out_data/out_valid are registered.
  - Sustained cost per window on the odd row is 2 input cycles plus 4 emit cycles.
- out_last is asserted with beat 3 of the window at row=IMG_HEIGHT-1, col=IMG_WIDTH-1; it is derived from the counters, not from in_last.
- Frame error handling:
  - in_last accepted at a non-final position: frame_error pulses, the partial window is discarded (no emit), counters clear to 0, state goes to FILL.
  - Final position accepted with in_last=0: frame_error pulses, but the final window is still emitted with out_last and counters wrap normally.
- Reset asserted mid-EMIT: the window is dropped, outputs return to reset values immediately, and the next frame starts at row 0/col 0.
- The line buffer is not cleared on reset (no reset on storage); an odd row is always preceded by a fresh even row.

Decomposition:
- Package pool_pkg:
  - constant POOL_WIN=2.
  - enum gather_state_t {FILL, PAIR_L, PAIR_R, EMIT}.
  - typedef for the 2-bit beat index.
  - shared with the pooling stage.
- Sub-module row_line_buffer:
  - IMG_WIDTH x DATA_WIDTH storage.
  - One synchronous write port, two combinational read ports (col-1, col).
  - No reset.
- FSM, counters and output registers live in the top module.

Test Plan:
- 4x4 frame (IMG_WIDTH=IMG_HEIGHT=4), values 0..15, in_valid always high, out_ready=1, in_last on 15:
  - out stream 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
  - out_last only with 15; frame_error never asserted.
  - in_ready low exactly 4 cycles per window.
- Same frame with out_ready=0 for 3 cycles while beat 1 (value 1) is presented: out_data stays 1 and out_valid stays high for the stall; stream order is unchanged; no element lost or duplicated.
- Back-to-back frames (values 0..15, then 100..115): the second frame emits 100,101,104,105,...; out_last fires once per frame.
- in_last on value 5 (row 1, col 1) of a 4x4 frame:
  - frame_error pulses once and window (0,1,4,5) is not emitted.
  - a following clean frame 0..15 produces the full correct 16-element stream.
- Reset asserted during beat 2 of the first window:
  - out_valid=0 and out_last=0 immediately (asynchronous reset).
  - after release, a full frame produces the correct stream from the beginning.
- Random in_valid gaps (about 50% duty) with 4x4 and 28x28 frames: output sequence matches a reference model of the window reorder; out_last count equals frame count.
